// File: rtl/controller_sequencer.sv
// controller_sequencer: uOP index sequencer with registered ALU flags, run/halt, runaway fault and retire counter; `define SEQ_STEP_EN adds a STEP single-step input
module controller_sequencer #(
  parameter int COUNT_W   = 16,
  parameter int FAULT_UOP = 6
) (
  input  logic               CLK,
  input  logic               RST_N,
  input  logic               RUN,
`ifdef SEQ_STEP_EN
  input  logic               STEP,
`endif
  input  logic               RESET_uOP,
  input  logic               READ_FLAGS,
  input  logic               ALU_ZERO,
  input  logic               ALU_COUT,
  output logic [2:0]         uOP,
  output logic               ZERO_FLAG,
  output logic               COUT_FLAG,
  output logic               HALTED,
  output logic               FAULT,
  output logic               INSTR_DONE,
  output logic [COUNT_W-1:0] RETIRED
);
  typedef enum logic [1:0] {BOOT, EXEC, HALT} state_e;
  localparam logic [2:0] FAULT_IDX = 3'(FAULT_UOP);
  localparam logic [2:0] IDLE_UOP  = 3'd7;
  state_e             state_q;
  logic [2:0]         uop_q;
  logic               zero_q, cout_q, halted_q, fault_q, done_q;
  logic [COUNT_W-1:0] retired_q;
  logic               step_go, single_mode;
`ifdef SEQ_STEP_EN
  logic step_q, single_q;
  assign step_go     = STEP & ~step_q;
  assign single_mode = single_q;
  // STEP edge detector; single_q marks an instruction launched by STEP so it halts at retire
  always_ff @(posedge CLK or negedge RST_N)
    if (!RST_N) begin
      step_q   <= 1'b0;
      single_q <= 1'b0;
    end else begin
      step_q   <= STEP;
      single_q <= (state_q != EXEC) ? (!RUN && step_go) : single_q;
    end
`else
  assign step_go     = 1'b0;
  assign single_mode = 1'b0;
`endif
  // sequencer FSM: uOP stepping, retire/halt decisions, fault, counter and flag capture
  always_ff @(posedge CLK or negedge RST_N)
    if (!RST_N) begin
      state_q   <= BOOT;
      uop_q     <= IDLE_UOP;
      zero_q    <= 1'b0;
      cout_q    <= 1'b0;
      halted_q  <= 1'b1;
      fault_q   <= 1'b0;
      done_q    <= 1'b0;
      retired_q <= '0;
    end else begin
      done_q <= 1'b0;
      if (READ_FLAGS) begin
        zero_q <= ALU_ZERO;
        cout_q <= ALU_COUT;
      end
      case (state_q)
        EXEC:
          if (uop_q == IDLE_UOP) begin
            if (RUN && !single_mode) uop_q <= '0;
            else begin
              state_q  <= HALT;
              halted_q <= 1'b1;
            end
          end else if (RESET_uOP) begin
            done_q    <= 1'b1;
            retired_q <= retired_q + 1'b1;
            if (RUN && !single_mode) uop_q <= '0;
            else begin
              uop_q    <= IDLE_UOP;
              state_q  <= HALT;
              halted_q <= 1'b1;
            end
          end else if (uop_q == FAULT_IDX) begin
            fault_q <= 1'b1;
            uop_q   <= IDLE_UOP;
          end else uop_q <= uop_q + 1'b1;
        BOOT, HALT:
          if (RUN || step_go) begin
            state_q  <= EXEC;
            uop_q    <= '0;
            halted_q <= 1'b0;
          end
        default: begin
          state_q  <= BOOT;
          uop_q    <= IDLE_UOP;
          halted_q <= 1'b1;
        end
      endcase
    end
  assign uOP        = uop_q;
  assign ZERO_FLAG  = zero_q;
  assign COUT_FLAG  = cout_q;
  assign HALTED     = halted_q;
  assign FAULT      = fault_q;
  assign INSTR_DONE = done_q;
  assign RETIRED    = retired_q;
endmodule

// File: tb/tb_controller_sequencer.sv
// tb_controller_sequencer: randomized and directed checks of controller_sequencer against a behavioural model
module tb_controller_sequencer;
  logic CLK = 1'b0, RST_N = 1'b0, RUN = 1'b0, STEP = 1'b0;
  logic RESET_uOP = 1'b0, READ_FLAGS = 1'b0, ALU_ZERO = 1'b0, ALU_COUT = 1'b0;
  logic [2:0] uOP;
  logic ZERO_FLAG, COUT_FLAG, HALTED, FAULT, INSTR_DONE;
  logic [3:0] RETIRED;
  int tests = 0, failed = 0;
  bit m_exec, m_z, m_c, m_fault, m_done, m_single, m_stepq;
  int m_uop, m_ret;
  controller_sequencer #(.COUNT_W(4), .FAULT_UOP(6)) dut (
    .CLK(CLK), .RST_N(RST_N), .RUN(RUN),
`ifdef SEQ_STEP_EN
    .STEP(STEP),
`endif
    .RESET_uOP(RESET_uOP), .READ_FLAGS(READ_FLAGS), .ALU_ZERO(ALU_ZERO), .ALU_COUT(ALU_COUT),
    .uOP(uOP), .ZERO_FLAG(ZERO_FLAG), .COUT_FLAG(COUT_FLAG), .HALTED(HALTED),
    .FAULT(FAULT), .INSTR_DONE(INSTR_DONE), .RETIRED(RETIRED));
  always #5 CLK = ~CLK;
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  wire [11:0] obs = {uOP, ZERO_FLAG, COUT_FLAG, HALTED, FAULT, INSTR_DONE, RETIRED};
  function automatic logic [11:0] exp_vec();
    return {3'(m_uop), m_z, m_c, !m_exec, m_fault, m_done, 4'(m_ret)};
  endfunction
  task automatic model_reset();
    m_exec = 0; m_uop = 7; m_z = 0; m_c = 0; m_fault = 0; m_done = 0; m_ret = 0;
    m_single = 0; m_stepq = 0;
  endtask
  task automatic do_reset();
    RUN = 0; STEP = 0; RESET_uOP = 0; READ_FLAGS = 0; ALU_ZERO = 0; ALU_COUT = 0;
    RST_N = 0;
    model_reset();
    #3;
    @(negedge CLK) RST_N = 1;
  endtask
  task automatic tick(input bit run, input bit ru, input bit rf, input bit z, input bit c, input bit st);
    bit rise;
    RUN = run; RESET_uOP = ru; READ_FLAGS = rf; ALU_ZERO = z; ALU_COUT = c; STEP = st;
    @(posedge CLK);
    rise = 0;
`ifdef SEQ_STEP_EN
    rise = st && !m_stepq;
`endif
    m_stepq = st;
    if (rf) begin m_z = z; m_c = c; end
    m_done = 0;
    if (!m_exec) begin
      if (run) begin m_exec = 1; m_uop = 0; m_single = 0; end
      else if (rise) begin m_exec = 1; m_uop = 0; m_single = 1; end
    end else if (m_uop == 7) begin
      if (run && !m_single) m_uop = 0; else m_exec = 0;
    end else if (ru) begin
      m_done = 1;
      m_ret = (m_ret + 1) % 16;
      if (run && !m_single) m_uop = 0; else begin m_uop = 7; m_exec = 0; end
    end else if (m_uop == 6) begin
      m_fault = 1; m_uop = 7;
    end else m_uop++;
    #1;
  endtask
  task automatic test_reset();
    do_reset();
    tests++;
    if (obs !== 12'b111_0_0_1_0_0_0000) begin
      failed++; $display("FAIL reset: got %h want %h", obs, 12'b111_0_0_1_0_0_0000);
    end
    tick(0, 0, 0, 0, 0, 0);
    tests++;
    if (obs !== exp_vec()) begin failed++; $display("FAIL boot_hold: got %h want %h", obs, exp_vec()); end
  endtask
  task automatic test_basic();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      tick(1, i == 4, 0, 0, 0, 0);
      tests++;
      if (obs !== exp_vec()) begin failed++; $display("FAIL basic[%0d]: got %h want %h", i, obs, exp_vec()); end
    end
    tests++;
    if ({uOP, INSTR_DONE, RETIRED} !== {3'd0, 1'b1, 4'd1}) begin
      failed++; $display("FAIL basic_retire: got %h want %h", {uOP, INSTR_DONE, RETIRED}, {3'd0, 1'b1, 4'd1});
    end
    tick(1, 0, 0, 0, 0, 0);
    tests++;
    if ({uOP, INSTR_DONE} !== {3'd1, 1'b0}) begin
      failed++; $display("FAIL basic_pulse: got %h want %h", {uOP, INSTR_DONE}, {3'd1, 1'b0});
    end
  endtask
  task automatic test_halt();
    bit r;
    do_reset();
    for (int i = 0; i < 9; i++) begin
      r = (i < 2) || (i == 8);
      tick(r, i >= 5, 0, 0, 0, 0);
      tests++;
      if (obs !== exp_vec()) begin failed++; $display("FAIL halt[%0d]: got %h want %h", i, obs, exp_vec()); end
      if (i == 5) begin
        tests++;
        if ({uOP, HALTED, RETIRED} !== {3'd7, 1'b1, 4'd1}) begin
          failed++; $display("FAIL halt_enter: got %h want %h", {uOP, HALTED, RETIRED}, {3'd7, 1'b1, 4'd1});
        end
      end
    end
    tests++;
    if ({uOP, HALTED, RETIRED} !== {3'd0, 1'b0, 4'd1}) begin
      failed++; $display("FAIL halt_resume: got %h want %h", {uOP, HALTED, RETIRED}, {3'd0, 1'b0, 4'd1});
    end
  endtask
  task automatic test_fault();
    do_reset();
    for (int i = 0; i < 8; i++) begin
      tick(1, 0, 0, 0, 0, 0);
      tests++;
      if (obs !== exp_vec()) begin failed++; $display("FAIL fault[%0d]: got %h want %h", i, obs, exp_vec()); end
    end
    tests++;
    if ({uOP, FAULT, HALTED, RETIRED} !== {3'd7, 1'b1, 1'b0, 4'd0}) begin
      failed++; $display("FAIL fault_idle: got %h want %h", {uOP, FAULT, HALTED, RETIRED}, {3'd7, 1'b1, 1'b0, 4'd0});
    end
    tick(1, 1, 0, 0, 0, 0);
    tests++;
    if ({uOP, FAULT, INSTR_DONE, RETIRED} !== {3'd0, 1'b1, 1'b0, 4'd0}) begin
      failed++; $display("FAIL fault_recover: got %h want %h", {uOP, FAULT, INSTR_DONE, RETIRED}, {3'd0, 1'b1, 1'b0, 4'd0});
    end
  endtask
  task automatic test_flags();
    do_reset();
    for (int i = 0; i < 5; i++) tick(1, 0, 0, 1, 1, 0);
    tick(1, 0, 1, 1, 0, 0);
    tests++;
    if ({ZERO_FLAG, COUT_FLAG} !== 2'b10) begin failed++; $display("FAIL flags_first: got %b want 10", {ZERO_FLAG, COUT_FLAG}); end
    tick(1, 0, 1, 0, 1, 0);
    tick(1, 1, 0, 1, 0, 0);
    for (int i = 0; i < 3; i++) begin
      tick(1, 0, 0, 1'($urandom), 1'($urandom), 0);
      tests++;
      if (obs !== exp_vec()) begin failed++; $display("FAIL flags_hold[%0d]: got %h want %h", i, obs, exp_vec()); end
    end
    tests++;
    if ({ZERO_FLAG, COUT_FLAG} !== 2'b01) begin failed++; $display("FAIL flags_last: got %b want 01", {ZERO_FLAG, COUT_FLAG}); end
  endtask
  task automatic test_wrap();
    do_reset();
    tick(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 16; i++) begin
      tick(1, 1, 0, 0, 0, 0);
      if (i == 14) begin
        tests++;
        if (RETIRED !== 4'd15) begin failed++; $display("FAIL wrap_15: got %0d want 15", RETIRED); end
      end
    end
    tests++;
    if ({RETIRED, INSTR_DONE, uOP} !== {4'd0, 1'b1, 3'd0}) begin
      failed++; $display("FAIL wrap_0: got %h want %h", {RETIRED, INSTR_DONE, uOP}, {4'd0, 1'b1, 3'd0});
    end
  endtask
  task automatic test_async_reset();
    do_reset();
    for (int i = 0; i < 4; i++) tick(1, i == 1, 1, 1, 1, 0);
    #2 RST_N = 0;
    model_reset();
    #1;
    tests++;
    if (obs !== 12'b111_0_0_1_0_0_0000) begin
      failed++; $display("FAIL async_reset: got %h want %h", obs, 12'b111_0_0_1_0_0_0000);
    end
    @(negedge CLK) RST_N = 1;
  endtask
  task automatic test_random();
    do_reset();
    for (int i = 0; i < 600; i++) begin
      tick($urandom_range(0, 7) != 0, $urandom_range(0, 5) == 0, $urandom_range(0, 2) == 0,
           1'($urandom), 1'($urandom), 1'($urandom));
      tests++;
      if (obs !== exp_vec()) begin failed++; $display("FAIL random[%0d]: got %h want %h", i, obs, exp_vec()); end
    end
  endtask
`ifdef SEQ_STEP_EN
  task automatic test_step();
    do_reset();
    tick(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 10; i++) begin
      tick(0, i == 3, 0, 0, 0, 1);
      tests++;
      if (obs !== exp_vec()) begin failed++; $display("FAIL step_held[%0d]: got %h want %h", i, obs, exp_vec()); end
    end
    tests++;
    if ({uOP, HALTED, RETIRED} !== {3'd7, 1'b1, 4'd1}) begin
      failed++; $display("FAIL step_once: got %h want %h", {uOP, HALTED, RETIRED}, {3'd7, 1'b1, 4'd1});
    end
    tick(0, 0, 0, 0, 0, 0);
    tick(0, 0, 0, 0, 0, 1);
    tests++;
    if ({uOP, HALTED} !== {3'd0, 1'b0}) begin failed++; $display("FAIL step_again: got %h want %h", {uOP, HALTED}, {3'd0, 1'b0}); end
    tick(1, 1, 0, 0, 0, 0);
    tests++;
    if ({uOP, HALTED, RETIRED} !== {3'd7, 1'b1, 4'd2}) begin
      failed++; $display("FAIL step_retire: got %h want %h", {uOP, HALTED, RETIRED}, {3'd7, 1'b1, 4'd2});
    end
  endtask
`endif
  initial begin
    test_reset();
    test_basic();
    test_halt();
    test_fault();
    test_flags();
    test_wrap();
    test_async_reset();
    test_random();
`ifdef SEQ_STEP_EN
    test_step();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
